input_vc_buffer: RTL

INPUT_VC_BUFFER -- requirements
Module: input_vc_buffer

---
 rtl/input_vc_buffer.sv | 89 ++++++++
 1 files changed

// File: rtl/input_vc_buffer.sv
// Two-VC single-entry input buffer: polarity picks the write VC, the other VC
// requests the forward or eject arbiter and hands its packet over on grant.
module input_vc_buffer #(
  parameter int DATA_WIDTH   = 64,
  parameter int HOP_MSB      = 55,
  parameter int STARVE_LIMIT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  polarity,
  input  logic                  in_send,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  rq_fwd,
  output logic                  rq_eject,
  input  logic                  gt_fwd,
  input  logic                  gt_eject,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_vc,
  output logic [1:0]            starve
);

  localparam logic [7:0] STARVE_CNT = 8'(STARVE_LIMIT);

  logic [1:0]            full_vec;
  logic [DATA_WIDTH-1:0] data_vec [2];
  logic                  rd_vc;
  logic                  rd_full;
  logic [7:0]            rd_hop;
  logic                  write_en;
  logic                  accept;

  assign rd_vc    = ~polarity;
  assign in_ready = ~full_vec[polarity];
  assign write_en = in_send & in_ready;
  assign rd_full  = full_vec[rd_vc];
  assign rd_hop   = data_vec[rd_vc][HOP_MSB -: 8];
  assign rq_eject = rd_full & (rd_hop == 8'd0);
  assign rq_fwd   = rd_full & (rd_hop != 8'd0);
  // A grant only counts on the line that is actually requesting
  assign accept   = (gt_fwd & rq_fwd) | (gt_eject & rq_eject);
  assign out_vc   = rd_vc;

  always_comb begin
    out_data = '0;
    if (rq_eject) begin
      out_data = data_vec[rd_vc];
    end else if (rq_fwd) begin
      out_data                  = data_vec[rd_vc];
      out_data[HOP_MSB -: 8]    = rd_hop - 8'd1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_vc
      logic                  is_wr;
      logic                  full_reg;
      logic [DATA_WIDTH-1:0] data_reg;
      logic [7:0]            wait_reg;

      assign is_wr = (gi == 0) ? ~polarity : polarity;

      // Write and read phases are exclusive per VC, so one branch owns the state each cycle
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          full_reg <= 1'b0;
          data_reg <= '0;
          wait_reg <= 8'd0;
        end else if (is_wr) begin
          if (write_en) begin
            data_reg <= in_data;
            full_reg <= 1'b1;
          end
        end else if (accept) begin
          full_reg <= 1'b0;
          wait_reg <= 8'd0;
        end else if (rd_full && wait_reg != 8'hFF) begin
          wait_reg <= wait_reg + 8'd1;
        end
      end

      assign full_vec[gi] = full_reg;
      assign data_vec[gi] = data_reg;
      assign starve[gi]   = (wait_reg >= STARVE_CNT);
    end
  endgenerate

endmodule
